// File: rtl/l1_miss_arbiter.sv
// Arbitrates the icache and dcache miss masters onto the single L2 wishbone slave.
// Data side has fixed priority; a starvation counter forces an icache grant after STARVE_LIMIT data grants.
module l1_miss_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned SEL_WIDTH    = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_cyc,
  input  logic                  i_stb,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_adr,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  input  logic [DATA_WIDTH-1:0] i_dat_w,
  output logic [DATA_WIDTH-1:0] i_dat_r,
  output logic                  i_ack,
  input  logic                  d_cyc,
  input  logic                  d_stb,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_adr,
  input  logic [SEL_WIDTH-1:0]  d_sel,
  input  logic [DATA_WIDTH-1:0] d_dat_w,
  output logic [DATA_WIDTH-1:0] d_dat_r,
  output logic                  d_ack,
  output logic                  l2_cyc,
  output logic                  l2_stb,
  output logic                  l2_we,
  output logic [ADDR_WIDTH-1:0] l2_adr,
  output logic [SEL_WIDTH-1:0]  l2_sel,
  output logic [DATA_WIDTH-1:0] l2_dat_w,
  input  logic [DATA_WIDTH-1:0] l2_dat_r,
  input  logic                  l2_ack,
  input  logic                  l2_rty,
  output logic                  grant_i,
  output logic                  grant_d
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             req_i, req_d;

  assign req_i = i_cyc & i_stb;
  assign req_d = d_cyc & d_stb;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Arbitration only happens in IDLE, which also provides the bubble between grants.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_d && (!req_i || (starve_cnt_q != LIMIT))) begin
          state_d = OWN_D;
          if (req_i && (starve_cnt_q < LIMIT)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else if (req_i) begin
          state_d      = OWN_I;
          starve_cnt_d = '0;
        end
      end
      OWN_I: if (l2_ack || l2_rty || !i_cyc) state_d = IDLE;
      OWN_D: if (l2_ack || l2_rty || !d_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner's bus is muxed straight through; ack returns with no added latency.
  always_comb begin
    l2_cyc   = 1'b0;
    l2_stb   = 1'b0;
    l2_we    = 1'b0;
    l2_adr   = '0;
    l2_sel   = '0;
    l2_dat_w = '0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    case (state_q)
      OWN_I: begin
        l2_cyc   = i_cyc;
        l2_stb   = i_stb;
        l2_we    = i_we;
        l2_adr   = i_adr;
        l2_sel   = i_sel;
        l2_dat_w = i_dat_w;
        i_ack    = l2_ack;
      end
      OWN_D: begin
        l2_cyc   = d_cyc;
        l2_stb   = d_stb;
        l2_we    = d_we;
        l2_adr   = d_adr;
        l2_sel   = d_sel;
        l2_dat_w = d_dat_w;
        d_ack    = l2_ack;
      end
      default: ;
    endcase
  end

  assign grant_i = (state_q == OWN_I);
  assign grant_d = (state_q == OWN_D);
  assign i_dat_r = l2_dat_r;
  assign d_dat_r = l2_dat_r;

endmodule
